// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: shares one memory read port and one memory write port
// among NUM_CONSUMERS load/store units. Requests are granted round-robin,
// served one at a time, and aborted with a sticky per-consumer error flag
// if memory does not answer within TIMEOUT_CYCLES waiting cycles.
module mem_rr_arbiter #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 16,
  parameter int NUM_CONSUMERS  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
  input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
  output logic [DATA_BITS-1:0]     consumer_read_data [NUM_CONSUMERS],
  input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
  input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
  input  logic [DATA_BITS-1:0]     consumer_write_data [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
  output logic                     mem_read_valid,
  output logic [ADDR_BITS-1:0]     mem_read_address,
  input  logic                     mem_read_ready,
  input  logic [DATA_BITS-1:0]     mem_read_data,
  output logic                     mem_write_valid,
  output logic [ADDR_BITS-1:0]     mem_write_address,
  output logic [DATA_BITS-1:0]     mem_write_data,
  input  logic                     mem_write_ready,
  output logic [NUM_CONSUMERS-1:0] timeout_error
);

  localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int CNT_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_READ_WAITING   = 3'd1,
    S_WRITE_WAITING  = 3'd2,
    S_READ_RELAYING  = 3'd3,
    S_WRITE_RELAYING = 3'd4
  } state_t;

  state_t              state_q;
  logic [IDX_BITS-1:0] idx_q;
  logic [IDX_BITS-1:0] last_grant_q;
  logic [CNT_BITS-1:0] cnt_q;

  logic                grant_found_d;
  logic [IDX_BITS-1:0] grant_idx_d;
  logic                grant_is_read_d;
  logic                tmo_hit_d;

  // Round-robin scan starting one past the last grant; the first consumer
  // with any valid wins, and a read beats a write on the same consumer.
  always_comb begin
    logic [IDX_BITS-1:0] cand;
    grant_found_d   = 1'b0;
    grant_idx_d     = '0;
    grant_is_read_d = 1'b0;
    cand            = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      cand = last_grant_q + IDX_BITS'(1) + IDX_BITS'(i);
      if (!grant_found_d && (consumer_read_valid[cand] || consumer_write_valid[cand])) begin
        grant_found_d   = 1'b1;
        grant_idx_d     = cand;
        grant_is_read_d = consumer_read_valid[cand];
      end else begin
        grant_found_d   = grant_found_d;
      end
    end
  end

  // Last permitted waiting cycle: without memory ready this one aborts.
  assign tmo_hit_d = (cnt_q == CNT_BITS'(TIMEOUT_CYCLES - 1));

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q              <= S_IDLE;
      idx_q                <= '0;
      last_grant_q         <= IDX_BITS'(NUM_CONSUMERS - 1);
      cnt_q                <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      timeout_error        <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        consumer_read_data[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_found_d) begin
            idx_q        <= grant_idx_d;
            last_grant_q <= grant_idx_d;
            cnt_q        <= '0;
            if (grant_is_read_d) begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= consumer_read_address[grant_idx_d];
              state_q          <= S_READ_WAITING;
            end else begin
              mem_write_valid   <= 1'b1;
              mem_write_address <= consumer_write_address[grant_idx_d];
              mem_write_data    <= consumer_write_data[grant_idx_d];
              state_q           <= S_WRITE_WAITING;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_READ_WAITING: begin
          if (mem_read_ready) begin
            mem_read_valid             <= 1'b0;
            consumer_read_data[idx_q]  <= mem_read_data;
            consumer_read_ready[idx_q] <= 1'b1;
            state_q                    <= S_READ_RELAYING;
          end else if (tmo_hit_d) begin
            mem_read_valid             <= 1'b0;
            timeout_error[idx_q]       <= 1'b1;
            consumer_read_data[idx_q]  <= '0;
            consumer_read_ready[idx_q] <= 1'b1;
            state_q                    <= S_READ_RELAYING;
          end else begin
            cnt_q <= cnt_q + CNT_BITS'(1);
          end
        end
        S_WRITE_WAITING: begin
          if (mem_write_ready) begin
            mem_write_valid             <= 1'b0;
            consumer_write_ready[idx_q] <= 1'b1;
            state_q                     <= S_WRITE_RELAYING;
          end else if (tmo_hit_d) begin
            mem_write_valid             <= 1'b0;
            timeout_error[idx_q]        <= 1'b1;
            consumer_write_ready[idx_q] <= 1'b1;
            state_q                     <= S_WRITE_RELAYING;
          end else begin
            cnt_q <= cnt_q + CNT_BITS'(1);
          end
        end
        S_READ_RELAYING: begin
          if (!consumer_read_valid[idx_q]) begin
            consumer_read_ready[idx_q] <= 1'b0;
            state_q                    <= S_IDLE;
          end else begin
            state_q <= S_READ_RELAYING;
          end
        end
        S_WRITE_RELAYING: begin
          if (!consumer_write_valid[idx_q]) begin
            consumer_write_ready[idx_q] <= 1'b0;
            state_q                     <= S_IDLE;
          end else begin
            state_q <= S_WRITE_RELAYING;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_rr_arbiter.md
MEM_RR_ARBITER -- requirements
Module: mem_rr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 16, memory data width.
REQ-003 SHALL have parameter NUM_CONSUMERS, default 4, number of requesting LSUs (power of two, >=2).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64, max cycles waiting on memory before abort (>=2).
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset (reset==0 resets on the rising clk edge).
REQ-007 SHALL have ports consumer_read_valid  input  NUM_CONSUMERS and consumer_read_address  input  ADDR_BITS x NUM_CONSUMERS  per-consumer read request.
REQ-008 SHALL have ports consumer_read_ready  output  NUM_CONSUMERS and consumer_read_data  output  DATA_BITS x NUM_CONSUMERS  per-consumer read completion.
REQ-009 SHALL have ports consumer_write_valid  input  NUM_CONSUMERS, consumer_write_address  input  ADDR_BITS x NUM_CONSUMERS, consumer_write_data  input  DATA_BITS x NUM_CONSUMERS  per-consumer write request.
REQ-010 SHALL have port consumer_write_ready  output  NUM_CONSUMERS  per-consumer write completion.
REQ-011 SHALL have ports mem_read_valid  output  1, mem_read_address  output  ADDR_BITS, mem_read_ready  input  1, mem_read_data  input  DATA_BITS  single memory read port.
REQ-012 SHALL have ports mem_write_valid  output  1, mem_write_address  output  ADDR_BITS, mem_write_data  output  DATA_BITS, mem_write_ready  input  1  single memory write port.
REQ-013 SHALL have port timeout_error  output  NUM_CONSUMERS  sticky per-consumer flag, set when that consumer's request aborts on timeout.

Function
REQ-014 SHALL implement states IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING, serving one request at a time.
REQ-015 SHALL, in IDLE, scan consumers round-robin starting at (last_grant+1) mod NUM_CONSUMERS; first consumer with read or write valid wins.
REQ-016 SHALL, when the winner has both read and write valid, serve the read first.
REQ-017 SHALL, on grant, on the next edge: latch consumer index, set last_grant to it, drive mem_*_valid=1 with registered address (and data for writes), enter *_WAITING, clear timeout counter.
REQ-018 SHALL hold mem address/data stable while mem_*_valid=1.
REQ-019 SHALL, in READ_WAITING with mem_read_ready=1: deassert mem_read_valid, register mem_read_data into consumer_read_data[idx], assert consumer_read_ready[idx], enter READ_RELAYING (1-cycle registered latency).
REQ-020 SHALL, in WRITE_WAITING with mem_write_ready=1: deassert mem_write_valid, assert consumer_write_ready[idx], enter WRITE_RELAYING.
REQ-021 SHALL increment the timeout counter each WAITING cycle without memory ready; on reaching TIMEOUT_CYCLES-1 without ready: deassert mem valid, set timeout_error[idx], assert the consumer ready (read data forced to 0), enter matching RELAYING.
REQ-022 SHALL treat memory ready on the same cycle as counter reaching limit as normal completion, no error.
REQ-023 SHALL, in RELAYING, hold consumer ready until the consumer drops its valid; on that edge deassert ready and return to IDLE; no new grant in that same cycle.
REQ-024 SHALL keep consumer_read_data[idx] stable until the next read completion for idx.
REQ-025 SHALL ignore consumer valids from non-granted consumers and leave their ready outputs 0.
REQ-026 SHALL ignore a drop of the granted consumer's valid during WAITING (memory transaction completes, then RELAYING exits next cycle).
REQ-027 SHALL wrap last_grant modulo NUM_CONSUMERS; with one persistent requester, it is granted each round.

Reset
REQ-028 SHALL, while reset==0 on a rising edge: state=IDLE, last_grant=NUM_CONSUMERS-1 (so consumer 0 has first priority), all mem_* and consumer_* outputs 0, timeout counter 0, timeout_error 0.
REQ-029 SHALL abort any in-flight transaction on reset without completing or flagging it.

Verification
REQ-030 Single read: consumer 2 reads addr 0x10, memory returns 0x1234 after 3 cycles -> consumer_read_ready[2]=1, data 0x1234, ready drops one edge after valid drops.
REQ-031 Round-robin: consumers 0,1,3 hold continuous writes -> grant order 0,1,3,0,1,3; no consumer granted twice before others.
REQ-032 Read+write both valid on consumer 1 -> read served first, then write on a later grant; mem_write_data matches.
REQ-033 Timeout: memory never answers consumer 0 read, TIMEOUT_CYCLES=8 -> mem_read_valid drops after 8 WAITING cycles, timeout_error=4'b0001, read data 0; next consumer served normally.
REQ-034 Ready on the limit cycle -> normal completion, timeout_error stays 0.
REQ-035 Reset asserted (low) during WRITE_WAITING -> next edge all outputs 0, state IDLE; after release consumer 0 wins first.
